proc_control_unit: RTL
======================

# proc_control_unit

Multi-cycle control unit sequencing the 16-bit processor datapath (register file R0–R7, operand register A, result register G, ALU, shared bus). It fetches an instruction word from `data_in`, decodes it, and drives register write enables, bus select, ALU operation and load strobes over 2 or 4 cycles, then signals completion. It sits beside the datapath inside `processor` and replaces ad-hoc control decode.

## Interface
- CNT_W, 16, width of the retired-instruction counter

- clock  in  1  rising-edge system clock
- reset  in  1  asynchronous, active-low reset
- run  in  1  start request; sampled in IDLE
- data_in  in  16  instruction word (IDLE) or immediate operand (T1 of mvi)
- reg_in  out  8  one-hot register-file write enables, bit n = Rn
- a_load  out  1  load A from bus
- g_load  out  1  load G from ALU
- bus_sel  out  4  bus source: 0–7 = Rn, 8 = data_in, 9 = G, others unused
- alu_op  out  3  ALU operation, equal to the opcode during T2, 000 otherwise
- done  out  1  high for exactly the final cycle of each instruction
- busy  out  1  high in any state other than IDLE
- ir  out  9  instruction register {opcode[8:6], Rx[5:3], Ry[2:0]}
- instr_count  out  CNT_W  instructions retired since reset

## Operation
- Instruction format: data_in[8:6] opcode, [5:3] Rx, [2:0] Ry; data_in[15:9] ignored.
- Opcodes: 000 mv Rx←Ry; 001 mvi Rx←next word; 010 add; 011 sub; 100 and; 101 or; 110 xor; 111 not (Rx←~Rx, Ry ignored). ALU ops write Rx←Rx op Ry.
- States: IDLE, T1, T2, T3 (binary encoded, registered).
- IDLE: all strobes low. If run=1: ir ← data_in[8:0] at the clock edge, go to T1. Else stay.
- T1, mv: bus_sel=Ry, reg_in[Rx]=1, done=1 → IDLE.
- T1, mvi: bus_sel=8, reg_in[Rx]=1, done=1 → IDLE; the immediate must be on data_in during T1.
- T1, ALU ops (010–111): bus_sel=Rx, a_load=1 → T2.
- T2: bus_sel=Ry (don't-care for not, drive Ry anyway), alu_op=opcode, g_load=1 → T3.
- T3: bus_sel=9, reg_in[Rx]=1, done=1 → IDLE.
- Outputs other than ir and instr_count are combinational decodes of state and ir. Unlisted strobes are 0, and bus_sel is 0 when not specified.
- Rx==Ry is legal with no special case.
- instr_count increments on every clock edge where done=1 and wraps modulo 2^CNT_W.

## Timing
- Reset (reset=0, async): state=IDLE, ir=0, instr_count=0. Outputs are therefore reg_in=0, a_load=g_load=0, bus_sel=0, alu_op=0, done=0, busy=0. A reset mid-instruction aborts it with no write strobe and no count.
- Deassertion is synchronous to the design: the first run sample happens at the first rising edge with reset=1.
- Latency from the run-sampling edge to the done cycle: mv/mvi take 1 cycle (T1). ALU ops take 3 cycles (T1, T2, T3).
- Total occupancy including IDLE: 2 cycles for mv/mvi, 4 cycles for ALU ops.
- run held high issues back-to-back instructions. After done the FSM spends exactly one IDLE cycle and fetches data_in on that edge. run is ignored outside IDLE.
- done and reg_in are asserted in the same cycle. The datapath captures on the edge ending that cycle.
- data_in changes during T2/T3 have no effect.

## Test plan
- Reset: assert reset=0 mid-T2 of an add. All outputs go to 0 immediately, state IDLE, instr_count=0. After release with run=0, the unit stays idle.
- mvi: run=1, data_in=0x0040 then 0x4911 in T1. Expect T1 with bus_sel=8, reg_in=0x01, done=1; instr_count=1; busy high for 1 cycle.
- mv: data_in=0x0008. Expect T1 with bus_sel=0, reg_in=0x02, done=1, total 2 cycles.
- add: data_in=0x0081. Expect T1 bus_sel=0 and a_load=1; T2 bus_sel=1, alu_op=010, g_load=1; T3 bus_sel=9, reg_in=0x01, done=1.
- Opcode sweep: 0x00C1, 0x0101, 0x0141, 0x0181, 0x01C1. alu_op in T2 equals 011, 100, 101, 110, 111; each takes 4 cycles; instr_count increments by 5.
- Back-to-back and wrap: with CNT_W=2 and run held high for 5 mv instructions, done pulses every 2nd cycle, busy toggles, and instr_count reads 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/proc_control_unit.sv
// Multi-cycle control unit for the 16-bit datapath: fetch, decode, and sequence
// mv/mvi in one cycle after fetch and ALU ops in three (A load, G load, write back).
module proc_control_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic [15:0]      data_in,
  output logic [7:0]       reg_in,
  output logic             a_load,
  output logic             g_load,
  output logic [3:0]       bus_sel,
  output logic [2:0]       alu_op,
  output logic             done,
  output logic             busy,
  output logic [8:0]       ir,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_T1   = 2'd1,
    S_T2   = 2'd2,
    S_T3   = 2'd3
  } state_e;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [3:0] SEL_DIN = 4'd8;
  localparam logic [3:0] SEL_G   = 4'd9;

  state_e           state_q, state_d;
  logic [8:0]       ir_q, ir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [2:0] opcode;
  logic [2:0] rx;
  logic [2:0] ry;
  logic [7:0] rx_onehot;

  assign opcode    = ir_q[8:6];
  assign rx        = ir_q[5:3];
  assign ry        = ir_q[2:0];
  assign rx_onehot = 8'b0000_0001 << rx;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    reg_in  = '0;
    a_load  = 1'b0;
    g_load  = 1'b0;
    bus_sel = '0;
    alu_op  = '0;
    done    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (run) begin
          ir_d    = data_in[8:0];
          state_d = S_T1;
        end
      end
      S_T1: begin
        if (opcode == OP_MV || opcode == OP_MVI) begin
          bus_sel = (opcode == OP_MVI) ? SEL_DIN : {1'b0, ry};
          reg_in  = rx_onehot;
          done    = 1'b1;
          state_d = S_IDLE;
        end else begin
          bus_sel = {1'b0, rx};
          a_load  = 1'b1;
          state_d = S_T2;
        end
      end
      S_T2: begin
        // Ry still drives the bus for 'not'; the ALU simply ignores it.
        bus_sel = {1'b0, ry};
        alu_op  = opcode;
        g_load  = 1'b1;
        state_d = S_T3;
      end
      S_T3: begin
        bus_sel = SEL_G;
        reg_in  = rx_onehot;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cnt_d = done ? cnt_q + CNT_W'(1) : cnt_q;

  assign busy        = (state_q != S_IDLE);
  assign ir          = ir_q;
  assign instr_count = cnt_q;

endmodule
